// File: rtl/time_display.sv
// time_display
//   Scanned six-digit seven-segment driver for the alarm-clock time path.
//   Converts binary hour/min/sec into BCD digit pairs and time-multiplexes
//   them onto one shared active-low segment bus. A whole frame is drawn from
//   one snapshot of the inputs, so a roll-over mid-frame never tears the
//   display. Digits selected by the blink mask are blanked during the odd
//   blink phase. The separator dot blinks while running and is steady while
//   setting.
//
// Parameters
//   SCAN_DIV   clk cycles per digit slot (six slots per frame)
//   BLINK_HALF clk cycles per blink half-period
//
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous, active-high reset
//   hour   binary hours   (0..23 expected; >= 100 shows dashes)
//   min    binary minutes (0..59 expected; >= 100 shows dashes)
//   sec    binary seconds (0..59 expected; >= 100 shows dashes)
//   blink  per-digit blink mask, bit5 = hour tens .. bit0 = sec ones
//   norm   1 = running, 0 = setting mode
//   an     digit enables, active-low one-hot, bit5 = hour tens .. bit0 = sec ones
//   seg    segments {g,f,e,d,c,b,a}, active-low
//   dp     decimal point, active-low
module time_display #(
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_HALF = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] hour,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  input  logic [5:0] blink,
  input  logic       norm,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Restoring compare/subtract by 80, 40, 20, 10. Exact for 0..99; larger
  // values are caught separately and shown as dashes.
  function automatic bcd_t to_bcd(input logic [6:0] v);
    bcd_t       r;
    logic [6:0] rem;
    rem = v;
    r   = '0;
    if (rem >= 7'd80) begin rem = rem - 7'd80; r.tens[3] = 1'b1; end
    if (rem >= 7'd40) begin rem = rem - 7'd40; r.tens[2] = 1'b1; end
    if (rem >= 7'd20) begin rem = rem - 7'd20; r.tens[1] = 1'b1; end
    if (rem >= 7'd10) begin rem = rem - 7'd10; r.tens[0] = 1'b1; end
    r.ones = rem[3:0];
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;
  logic [2:0]         idx;
  logic [6:0]         hour_s, min_s, sec_s;
  logic [5:0]         blink_s;

  logic               scan_tick;
  logic               frame_wrap;
  logic [2:0]         idx_next;
  logic [6:0]         f_hour, f_min, f_sec, field;
  logic [5:0]         f_blink;
  bcd_t               bcd;
  logic [5:0]         an_next;
  logic [6:0]         seg_next;
  logic               dp_next;

  assign scan_tick  = (scan_cnt == SCAN_LAST);
  assign frame_wrap = (idx == 3'd0);

  // Free-running counters; neither depends on norm or on the other.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (scan_tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // On a frame wrap the new digit is drawn from the live inputs, which are
  // simultaneously captured into the shadows for the remaining five slots.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves a value unassigned and infers a latch.
    idx_next = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    f_hour   = frame_wrap ? hour  : hour_s;
    f_min    = frame_wrap ? min   : min_s;
    f_sec    = frame_wrap ? sec   : sec_s;
    f_blink  = frame_wrap ? blink : blink_s;

    case (idx_next)
      3'd5, 3'd4: field = f_hour;
      3'd3, 3'd2: field = f_min;
      default:    field = f_sec;
    endcase

    bcd = to_bcd(field);

    // Odd indices are the tens digits of each field.
    if (field >= 7'd100) begin
      seg_next = SEG_DASH;
    end else if (idx_next[0]) begin
      seg_next = seg_code(bcd.tens);
    end else begin
      seg_next = seg_code(bcd.ones);
    end

    if (f_blink[idx_next] && phase) begin
      seg_next = SEG_BLANK;
    end

    an_next = ~(6'b000001 << idx_next);
    dp_next = ~(((idx_next == 3'd4) || (idx_next == 3'd2)) && (~norm || ~phase));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= 3'd0;
      hour_s  <= '0;
      min_s   <= '0;
      sec_s   <= '0;
      blink_s <= '0;
      an      <= 6'b111111;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else if (scan_tick) begin
      idx <= idx_next;
      if (frame_wrap) begin
        hour_s  <= hour;
        min_s   <= min;
        sec_s   <= sec;
        blink_s <= blink;
      end
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_time_display.sv
// tb_time_display
//   Self-checking bench for time_display with SCAN_DIV=4, BLINK_HALF=16.
//   A reference model derives the expected display purely from the number of
//   clock edges since reset: which tick it is, which digit that tick selects,
//   which blink half-period is in force, and the snapshot taken at each frame
//   start. Directed steps cover reset, decode, snapshot and mid-frame reset;
//   randomized inputs cover blinking, the running dot and out-of-range values.
module tb_time_display;

  localparam int SD = 4;
  localparam int BH = 16;

  logic       clk;
  logic       rst;
  logic [6:0] hour, min, sec;
  logic [5:0] blink;
  logic       norm;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  time_display #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
    .clk   (clk),
    .rst   (rst),
    .hour  (hour),
    .min   (min),
    .sec   (sec),
    .blink (blink),
    .norm  (norm),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         edge_n;
  int         m_hour, m_min, m_sec;
  logic [5:0] m_blink;
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  task automatic model_tick();
    int k, d, ph, v, dig;
    k  = edge_n / SD;
    d  = 5 - ((k - 1) % 6);
    if (d == 5) begin
      m_hour  = int'(hour);
      m_min   = int'(min);
      m_sec   = int'(sec);
      m_blink = blink;
    end
    // Blink half-period in force just before this edge.
    ph = ((edge_n - 1) / BH) % 2;
    v  = (d >= 4) ? m_hour : (d >= 2) ? m_min : m_sec;
    if (v >= 100) begin
      exp_seg = 7'h3F;
    end else begin
      dig     = (d % 2 == 1) ? v / 10 : v % 10;
      exp_seg = seg_tbl[dig];
    end
    if (m_blink[d] && ph == 1) exp_seg = 7'h7F;
    exp_an = 6'h3F ^ (6'h01 << d);
    exp_dp = ((d == 4 || d == 2) && (!norm || ph == 0)) ? 1'b0 : 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n  = 0;
      m_hour  = 0;
      m_min   = 0;
      m_sec   = 0;
      m_blink = '0;
      exp_an  = 6'h3F;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      edge_n = edge_n + 1;
      if (edge_n % SD == 0) model_tick();
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check("model_an",  32'(an),  32'(exp_an));
      check("model_seg", 32'(seg), 32'(exp_seg));
      check("model_dp",  32'(dp),  32'(exp_dp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [6:0] dec_seg [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};

  initial begin
    rst   = 1'b1;
    hour  = 7'd12;
    min   = 7'd34;
    sec   = 7'd56;
    blink = 6'b000000;
    norm  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_an",  32'(an),  32'h3F);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp",  32'(dp),  32'h1);

    // First tick lands on the 4th edge after release.
    rst = 1'b0;
    run_cycles(3);
    check("pre_tick_an", 32'(an), 32'h3F);
    run_cycles(1);
    check("first_tick_an", 32'(an), 32'(6'b011111));

    // Decode 12:34:56, one slot at a time.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) run_cycles(SD);
      check("decode_an",  32'(an),  32'(6'h3F ^ (6'h01 << (5 - i))));
      check("decode_seg", 32'(seg), 32'(dec_seg[i]));
      check("decode_dp",  32'(dp),  (i == 1 || i == 3) ? 32'h0 : 32'h1);
    end

    // Snapshot: change sec during the digit-3 slot of the next frame.
    run_cycles(3 * SD);
    check("snap_d3_an", 32'(an), 32'(6'b110111));
    sec = 7'd57;
    run_cycles(2 * SD);
    check("snap_old_tens", 32'(seg), 32'h12);
    run_cycles(SD);
    check("snap_old_ones", 32'(seg), 32'h02);
    run_cycles(5 * SD);
    check("snap_new_tens", 32'(seg), 32'h12);
    run_cycles(SD);
    check("snap_new_ones", 32'(seg), 32'h78);

    // Blinking minutes in setting mode.
    blink = 6'b001100;
    run_cycles(200);

    // Running dot.
    blink = 6'b000000;
    norm  = 1'b1;
    run_cycles(200);

    // Asynchronous reset mid-frame.
    run_cycles(6);
    rst = 1'b1;
    #1;
    check("midrst_an",  32'(an),  32'h3F);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp",  32'(dp),  32'h1);
    run_cycles(2);
    rst = 1'b0;
    run_cycles(SD);
    check("midrst_first_an", 32'(an), 32'(6'b011111));

    // Out-of-range minutes and boundary hour/sec values.
    hour  = 7'd23;
    min   = 7'd100;
    sec   = 7'd0;
    norm  = 1'b0;
    run_cycles(60);

    // Randomized inputs, including occasional out-of-range fields.
    for (int i = 0; i < 40; i++) begin
      hour  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 23));
      min   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 59));
      sec   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 59));
      blink = 6'($urandom);
      norm  = 1'($urandom);
      run_cycles($urandom_range(1, 60));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_display.md
# time_display

Scanned six-digit seven-segment driver for the alarm-clock time path. It consumes the binary hour/min/sec values and the per-digit blink mask produced by the clock/setting block, converts each field to two BCD digits, and multiplexes them onto one shared segment bus. A field-blink phase blanks the digits under edit, and a separator dot marks normal versus setting mode. It sits between the time-keeping block and the board's display pins.

## Interface

- SCAN_DIV, 1000: clk cycles per digit slot (1 MHz clk gives a 1 ms slot and a 6 ms frame).
- BLINK_HALF, 250000: clk cycles per blink half-period (2 Hz blink at 1 MHz).
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- hour  in  7  binary hours (expected 0–23).
- min  in  7  binary minutes (expected 0–59).
- sec  in  7  binary seconds (expected 0–59).
- blink  in  6  per-digit blink mask:
  - bit5/4 hour tens/ones
  - bit3/2 min tens/ones
  - bit1/0 sec tens/ones
- norm  in  1  1 = running, 0 = setting mode.
- an  out  6  digit enables, active-low, one-hot-low; bit5 = hour tens … bit0 = sec ones.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation

- **Scan counter.** scan_cnt counts 0..SCAN_DIV-1 and wraps. The cycle where scan_cnt==SCAN_DIV-1 is a *scan tick*.
- **Digit index.** idx ranges 0..5 and moves on each scan tick: 0→5, otherwise idx-1. Display order is therefore 5,4,3,2,1,0,5,…
- **Snapshot.** On the 0→5 transition, hour/min/sec/blink are latched into shadow registers. All six digits of one frame come from a single snapshot, so there is no tearing when seconds roll over mid-frame. norm is sampled live on each tick.
- **BCD conversion** (per 7-bit field v):
  - v ≤ 99: tens = v/10, ones = v%10, using compare/subtract; no divider IP.
  - v ≥ 100: both digits of that field show a dash, seg = 7'h3F.
- **Segment codes** (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - blank = 7F
- **Blink phase.** blink_cnt counts 0..BLINK_HALF-1; phase toggles on wrap. Phase = 0 is visible.
- **Blanking.** If the shadow blink bit of the selected digit is 1 and phase = 1, seg = 7'h7F. an still selects the digit.
- **Separator dot.**
  - dp = 0 only on digits 4 and 2, and only when (norm=1 and phase=0) or norm=0.
  - So the dot blinks while running and stays steady in setting mode. Otherwise dp = 1.
  - The dot is not blanked by the blink mask.

## Timing

- **Reset values.**
  - Outputs: an=6'b111111, seg=7'h7F, dp=1.
  - Internal: scan_cnt=0, idx=0, blink_cnt=0, phase=0, shadows=0.
- **Output registration.** an/seg/dp are registered and update only on scan ticks. They are driven from the new idx and, on a wrap, the newly latched snapshot in the same edge.
- **First outputs.** After reset deassertion, the first tick occurs on the SCAN_DIV-th rising edge. It drives digit 5 from inputs sampled at that edge.
- **Phase latency.** A phase toggle between ticks becomes visible at the next tick, so blank latency is ≤ SCAN_DIV cycles.
- **Input-change latency.** An input change becomes visible within ≤ 6·SCAN_DIV cycles (next frame), never mid-frame.
- **Reset mid-frame.** Asserting rst mid-frame forces reset values immediately (asynchronous). No partial digit persists.
- **Counter independence.** scan_cnt and blink_cnt are independent free-running counters. Both continue regardless of norm.

## Test plan

Use SCAN_DIV=4 and BLINK_HALF=16 throughout.

- **Reset:** assert rst mid-frame → an=3F, seg=7F, dp=1 the same cycle. After release, first change is at edge 4: an=6'b011111.
- **Decode:** hour=12, min=34, sec=56, blink=0, norm=0 → successive slots show seg 79, 24, 30, 19, 12, 02. dp=0 only with an=101111 and an=111011.
- **Snapshot:** change sec 56→57 during the digit-3 slot → current frame still shows 5,6 on digits 1/0; next frame shows 5,7.
- **Blink:** blink=6'b001100, min=34 → digits 3/2 show 7F while phase=1 and 30/19 while phase=0. Hour and sec digits are unaffected. dp stays 0 on digits 4/2 because norm=0.
- **Running dot:** norm=1, blink=0 → dp on digits 4/2 toggles every 16 cycles, in step with phase.
- **Out of range:** min=100 → digits 3/2 show 3F. hour=23 shows 24/30; sec=0 shows 40/40.
